// File: rtl/midi_uart_fifo_if.sv
// Host-side bundle of the MIDI UART: RX stream with status tag, realtime
// output, sticky error flags and the TX push port.
interface midi_uart_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_status;
  logic [7:0] rx_byte_nr;
  logic       rt_valid;
  logic [7:0] rt_data;
  logic       rx_framing_err;
  logic       rx_overflow;
  logic       err_clr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;

  modport slave (
    output rx_data, rx_valid, rx_status, rx_byte_nr, rt_valid, rt_data,
           rx_framing_err, rx_overflow, tx_ready, tx_busy,
    input  rx_ready, err_clr, tx_data, tx_valid
  );

  modport master (
    input  rx_data, rx_valid, rx_status, rx_byte_nr, rt_valid, rt_data,
           rx_framing_err, rx_overflow, tx_ready, tx_busy,
    output rx_ready, err_clr, tx_data, tx_valid
  );
endinterface

// File: rtl/midi_uart_fifo.sv
// FIFO-buffered MIDI UART: oversampled majority-vote RX with running-status tagging,
// queued TX. Define MIDI_TX_RUNNING_STATUS_EN to drop repeated TX status bytes.
module midi_uart_fifo #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 31250,
  parameter int OVERSAMPLE = 16,
  parameter int RX_DEPTH   = 16,
  parameter int TX_DEPTH   = 16
) (
  input  logic CLOCK_25,
  input  logic iRST_N,
  input  logic midi_rxd,
  output logic midi_txd,
  midi_uart_fifo_if.slave bus
);
  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_PRE   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  OS_POST  = OS_W'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_SYNC, TX_START, TX_DATA, TX_STOP} tx_state_t;

  rx_state_t        rx_state, rx_state_nx;
  logic             rxd_m, rxd_s, rxd_d;
  logic [DIV_W-1:0] rx_div;
  logic [OS_W-1:0]  rx_os;
  logic [2:0]       rx_bit;
  logic [1:0]       rx_smp;
  logic [7:0]       rx_shift, run_status, run_nr, status_nx, nr_nx, rt_data_r;
  logic             rx_tick, rx_deliver, rx_ferr, is_rt, rt_valid_r, ferr_r, ovf_r, maj;

  always_ff @(posedge CLOCK_25 or negedge iRST_N)
    if (!iRST_N) {rxd_d, rxd_s, rxd_m} <= 3'b111;
    else         {rxd_d, rxd_s, rxd_m} <= {rxd_s, rxd_m, midi_rxd};

  // Tick index in rx_os is the one the next tick carries; the start edge counts as tick 0.
  assign rx_tick = (rx_div == '0) && (rx_state != RX_IDLE);
  assign maj     = (rx_smp[0] & rx_smp[1]) | (rx_smp[0] & rxd_s) | (rx_smp[1] & rxd_s);

  always_ff @(posedge CLOCK_25 or negedge iRST_N)
    if (!iRST_N) rx_state <= RX_IDLE;
    else         rx_state <= rx_state_nx;

  always_comb begin
    rx_state_nx = rx_state;
    rx_deliver  = 1'b0;
    rx_ferr     = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rxd_d && !rxd_s) rx_state_nx = RX_START;
      RX_START: if (rx_tick) begin
                  if (rx_os == OS_MID && rxd_s) rx_state_nx = RX_IDLE;
                  else if (rx_os == OS_LAST)    rx_state_nx = RX_DATA;
                end
      RX_DATA:  if (rx_tick && rx_os == OS_POST && rx_bit == 3'd7) rx_state_nx = RX_STOP;
      RX_STOP:  if (rx_tick && rx_os == OS_MID) begin
                  if (rxd_s) begin rx_state_nx = RX_IDLE;  rx_deliver = 1'b1; end
                  else       begin rx_state_nx = RX_BREAK; rx_ferr    = 1'b1; end
                end
      RX_BREAK: if (rxd_s) rx_state_nx = RX_IDLE;
      default:  rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25 or negedge iRST_N)
    if (!iRST_N) begin
      rx_div <= DIV_LAST; rx_os <= OS_W'(1); rx_bit <= '0; rx_smp <= '0; rx_shift <= '0;
    end else if (rx_state == RX_IDLE) begin
      rx_div <= DIV_LAST; rx_os <= OS_W'(1); rx_bit <= '0;
    end else if (rx_tick) begin
      rx_div <= DIV_LAST;
      rx_os  <= (rx_os == OS_LAST) ? '0 : rx_os + 1'b1;
      if (rx_state == RX_DATA) begin
        if (rx_os == OS_PRE) rx_smp[0] <= rxd_s;
        if (rx_os == OS_MID) rx_smp[1] <= rxd_s;
        if (rx_os == OS_POST) begin
          rx_shift <= {maj, rx_shift[7:1]};
          rx_bit   <= rx_bit + 1'b1;
        end
      end
    end else begin
      rx_div <= rx_div - 1'b1;
    end

  assign is_rt = (rx_shift[7:3] == 5'b11111);
  always_comb begin
    status_nx = run_status;
    nr_nx     = (run_nr == 8'hFF) ? 8'hFF : run_nr + 8'd1;
    if (rx_shift[7]) begin
      nr_nx = 8'd0;
      if (rx_shift != 8'hF7) status_nx = rx_shift;
    end
  end

  always_ff @(posedge CLOCK_25 or negedge iRST_N)
    if (!iRST_N) begin
      run_status <= '0; run_nr <= '0; rt_data_r <= '0; rt_valid_r <= 1'b0;
    end else begin
      rt_valid_r <= rx_deliver & is_rt;
      if (rx_deliver & is_rt) rt_data_r <= rx_shift;
      if (rx_deliver & !is_rt) begin
        run_status <= status_nx;
        run_nr     <= nr_nx;
      end
    end

  logic [23:0]    rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wp, rx_rp, rx_cnt;
  logic           rx_empty, rx_full, rx_pop, rx_wr_req, rx_wr;

  assign rx_cnt    = rx_wp - rx_rp;
  assign rx_empty  = (rx_cnt == '0);
  assign rx_full   = (rx_cnt == (RX_AW + 1)'(RX_DEPTH));
  assign rx_pop    = !rx_empty && bus.rx_ready;
  assign rx_wr_req = rx_deliver && !is_rt;
  // A simultaneous pop frees the slot being written, so a full FIFO still accepts.
  assign rx_wr     = rx_wr_req && (!rx_full || rx_pop);

  always_ff @(posedge CLOCK_25)
    if (rx_wr) rx_mem[rx_wp[RX_AW-1:0]] <= {rx_shift, status_nx, nr_nx};

  always_ff @(posedge CLOCK_25 or negedge iRST_N)
    if (!iRST_N) begin
      rx_wp <= '0; rx_rp <= '0; ferr_r <= 1'b0; ovf_r <= 1'b0;
    end else begin
      if (rx_wr)  rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      if (rx_ferr)          ferr_r <= 1'b1;
      else if (bus.err_clr) ferr_r <= 1'b0;
      if (rx_wr_req && !rx_wr) ovf_r <= 1'b1;
      else if (bus.err_clr)    ovf_r <= 1'b0;
    end

  assign bus.rx_valid = !rx_empty;
  assign {bus.rx_data, bus.rx_status, bus.rx_byte_nr} = rx_empty ? 24'd0 : rx_mem[rx_rp[RX_AW-1:0]];
  assign bus.rt_valid       = rt_valid_r;
  assign bus.rt_data        = rt_data_r;
  assign bus.rx_framing_err = ferr_r;
  assign bus.rx_overflow    = ovf_r;

  tx_state_t        tx_state, tx_state_nx;
  logic [DIV_W-1:0] tx_div;
  logic [OS_W-1:0]  tx_os;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [7:0]       tx_head, tx_shift, tx_next;
  logic [TX_AW:0]   tx_wp, tx_rp, tx_cnt;
  logic             tx_tick, tx_empty, tx_full, tx_push, tx_pop, tx_take, tx_drop, tx_have, bit_end;

  assign tx_tick  = (tx_div == '0);
  assign tx_cnt   = tx_wp - tx_rp;
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == (TX_AW + 1)'(TX_DEPTH));
  assign tx_push  = bus.tx_valid && !tx_full;
  assign tx_head  = tx_mem[tx_rp[TX_AW-1:0]];
  // The next byte is fetched during the stop bit so back-to-back frames have no gap.
  assign tx_pop   = !tx_empty && !tx_have && (tx_state == TX_LOAD || tx_state == TX_STOP);
  assign tx_take  = tx_pop && !tx_drop;
  assign bit_end  = tx_tick && (tx_os == OS_LAST);

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] tx_last;
  assign tx_drop = tx_head[7] && (tx_head[7:4] != 4'hF) && (tx_head == tx_last);
  always_ff @(posedge CLOCK_25 or negedge iRST_N)
    if (!iRST_N) tx_last <= '0;
    else if (tx_take) begin
      if (tx_head[7] && tx_head[7:4] != 4'hF) tx_last <= tx_head;
      else if (tx_head[7:3] == 5'b11110)      tx_last <= '0;
    end
`else
  assign tx_drop = 1'b0;
`endif

  always_ff @(posedge CLOCK_25)
    if (tx_push) tx_mem[tx_wp[TX_AW-1:0]] <= bus.tx_data;

  always_ff @(posedge CLOCK_25 or negedge iRST_N)
    if (!iRST_N) tx_state <= TX_IDLE;
    else         tx_state <= tx_state_nx;

  always_comb begin
    tx_state_nx = tx_state;
    case (tx_state)
      TX_IDLE:  if (!tx_empty) tx_state_nx = TX_LOAD;
      TX_LOAD:  if (tx_take) tx_state_nx = TX_SYNC;
                else if (tx_empty) tx_state_nx = TX_IDLE;
      TX_SYNC:  if (tx_tick) tx_state_nx = TX_START;
      TX_START: if (bit_end) tx_state_nx = TX_DATA;
      TX_DATA:  if (bit_end && tx_bit == 3'd7) tx_state_nx = TX_STOP;
      TX_STOP:  if (bit_end) tx_state_nx = (tx_have || tx_take) ? TX_START : TX_IDLE;
      default:  tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25 or negedge iRST_N)
    if (!iRST_N) begin
      tx_div <= DIV_LAST; tx_os <= '0; tx_bit <= '0; tx_shift <= '0; tx_next <= '0;
      tx_have <= 1'b0; tx_wp <= '0; tx_rp <= '0; midi_txd <= 1'b1;
    end else begin
      tx_div <= tx_tick ? DIV_LAST : tx_div - 1'b1;
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_state_nx == TX_START && tx_state != TX_START) begin
        tx_shift <= tx_have ? tx_next : tx_head;
        tx_have  <= 1'b0;
        tx_bit   <= '0;
      end else if (tx_take) begin
        tx_next <= tx_head;
        tx_have <= 1'b1;
      end
      if (tx_state == TX_START || tx_state == TX_DATA || tx_state == TX_STOP) begin
        if (tx_tick) tx_os <= (tx_os == OS_LAST) ? '0 : tx_os + 1'b1;
        if (bit_end && tx_state == TX_DATA) begin
          tx_shift <= {1'b1, tx_shift[7:1]};
          tx_bit   <= tx_bit + 1'b1;
        end
      end else begin
        tx_os <= '0;
      end
      case (tx_state)
        TX_START: midi_txd <= 1'b0;
        TX_DATA:  midi_txd <= tx_shift[0];
        default:  midi_txd <= 1'b1;
      endcase
    end

  assign bus.tx_ready = !tx_full;
  assign bus.tx_busy  = (tx_state != TX_IDLE) || !tx_empty;
endmodule

// File: tb/tb_midi_uart_fifo.sv
// Scoreboard bench for midi_uart_fifo: directed RX frames and TX pushes, with
// independent monitors for the RX FIFO, realtime output and serial TX line.
module tb_midi_uart_fifo;
  localparam int CLK_HZ = 25_000_000;
  localparam int BAUD   = 390_625;
  localparam int OS     = 16;
  localparam int DEPTH  = 16;
  localparam int BIT    = CLK_HZ / BAUD;
`ifdef MIDI_TX_RUNNING_STATUS_EN
  localparam int N_TX = 3;
`else
  localparam int N_TX = 4;
`endif

  logic CLOCK_25 = 1'b0;
  logic iRST_N   = 1'b0;
  logic midi_rxd = 1'b1;
  logic midi_txd;

  midi_uart_fifo_if bus ();

  midi_uart_fifo #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH)
  ) dut (
    .CLOCK_25(CLOCK_25), .iRST_N(iRST_N), .midi_rxd(midi_rxd), .midi_txd(midi_txd), .bus(bus)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  logic [23:0] rx_exp[$];
  logic [7:0]  rt_exp[$];
  logic [7:0]  tx_exp[$];
  int unsigned tx_starts[$];
  logic        rt_prev = 1'b0;

  always @(posedge CLOCK_25) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLOCK_25);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    midi_rxd = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      midi_rxd = b[i];
      wait_clk(BIT);
    end
    midi_rxd = stop;
    wait_clk(BIT);
    midi_rxd = 1'b1;
    if (!stop) wait_clk(BIT);
  endtask

  always @(negedge CLOCK_25) begin
    if (iRST_N && bus.rx_valid && bus.rx_ready) begin
      if (rx_exp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rx_unexpected: got entry %h, expected none",
                 {bus.rx_data, bus.rx_status, bus.rx_byte_nr});
      end else begin
        check("rx_entry", 32'({bus.rx_data, bus.rx_status, bus.rx_byte_nr}), 32'(rx_exp.pop_front()));
      end
    end
  end

  always @(negedge CLOCK_25) begin
    if (iRST_N && bus.rt_valid) begin
      check("rt_pulse_width", 32'(rt_prev), 32'(0));
      if (rt_exp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rt_unexpected: got %h, expected none", bus.rt_data);
      end else begin
        check("rt_data", 32'(bus.rt_data), 32'(rt_exp.pop_front()));
      end
    end
    rt_prev = bus.rt_valid;
  end

  // Decode the serial line by sampling mid-bit, timed from the falling start edge.
  initial begin
    logic       prev;
    logic [7:0] b;
    logic       sb, pb;
    prev = 1'b1;
    forever begin
      @(negedge CLOCK_25);
      if (iRST_N && prev && !midi_txd) begin
        tx_starts.push_back(cyc);
        repeat (BIT / 2) @(negedge CLOCK_25);
        sb = midi_txd;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge CLOCK_25);
          b[i] = midi_txd;
        end
        repeat (BIT) @(negedge CLOCK_25);
        pb = midi_txd;
        check("tx_start_bit", 32'(sb), 32'(0));
        check("tx_stop_bit", 32'(pb), 32'(1));
        if (tx_exp.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_unexpected: got frame %h, expected none", b);
        end else begin
          check("tx_byte", 32'(b), 32'(tx_exp.pop_front()));
        end
      end
      prev = midi_txd;
    end
  end

  initial begin
    repeat (80000) @(posedge CLOCK_25);
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_ready = 1'b1;
    bus.err_clr  = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    wait_clk(5);
    iRST_N = 1'b1;
    @(negedge CLOCK_25);
    check("rst_midi_txd", 32'(midi_txd), 32'(1));
    check("rst_tx_ready", 32'(bus.tx_ready), 32'(1));
    check("rst_tx_busy", 32'(bus.tx_busy), 32'(0));
    check("rst_rx_valid", 32'(bus.rx_valid), 32'(0));
    check("rst_rt_valid", 32'(bus.rt_valid), 32'(0));
    check("rst_rx_head", 32'({bus.rx_data, bus.rx_status, bus.rx_byte_nr}), 32'(0));
    check("rst_rt_data", 32'(bus.rt_data), 32'(0));
    check("rst_flags", 32'({bus.rx_framing_err, bus.rx_overflow}), 32'(0));
    wait_clk(2);

    // Note-on with two data bytes.
    rx_exp.push_back(24'h90_90_00);
    rx_exp.push_back(24'h3C_90_01);
    rx_exp.push_back(24'h64_90_02);
    send_rx(8'h90, 1'b1);
    send_rx(8'h3C, 1'b1);
    send_rx(8'h64, 1'b1);
    wait_clk(BIT);
    check("t1_rx_pending", 32'(rx_exp.size()), 32'(0));

    // Realtime byte interleaved in running status.
    rx_exp.push_back(24'h90_90_00);
    rx_exp.push_back(24'h3C_90_01);
    rx_exp.push_back(24'h40_90_02);
    rt_exp.push_back(8'hF8);
    send_rx(8'h90, 1'b1);
    send_rx(8'h3C, 1'b1);
    send_rx(8'hF8, 1'b1);
    send_rx(8'h40, 1'b1);
    wait_clk(BIT);
    check("t2_rx_pending", 32'(rx_exp.size()), 32'(0));
    check("t2_rt_pending", 32'(rt_exp.size()), 32'(0));
    check("t2_rt_held", 32'(bus.rt_data), 32'(8'hF8));

    // Short glitch: a false start, then a normal byte.
    midi_rxd = 1'b0;
    wait_clk(BIT * 300 / 800);
    midi_rxd = 1'b1;
    wait_clk(3 * BIT);
    @(negedge CLOCK_25);
    check("t3_rx_valid", 32'(bus.rx_valid), 32'(0));
    check("t3_flags", 32'({bus.rx_framing_err, bus.rx_overflow}), 32'(0));
    rx_exp.push_back(24'h41_90_03);
    send_rx(8'h41, 1'b1);
    wait_clk(BIT);
    check("t3_rx_pending", 32'(rx_exp.size()), 32'(0));

    // Framing error: byte discarded, flag sticky until err_clr.
    send_rx(8'h55, 1'b0);
    wait_clk(BIT);
    @(negedge CLOCK_25);
    check("t4_framing_err", 32'(bus.rx_framing_err), 32'(1));
    check("t4_rx_valid", 32'(bus.rx_valid), 32'(0));
    bus.err_clr = 1'b1;
    wait_clk(1);
    bus.err_clr = 1'b0;
    @(negedge CLOCK_25);
    check("t4_framing_clr", 32'(bus.rx_framing_err), 32'(0));
    rx_exp.push_back(24'h42_90_04);
    send_rx(8'h42, 1'b1);
    wait_clk(BIT);
    check("t4_rx_pending", 32'(rx_exp.size()), 32'(0));

    // Overflow: 17 bytes into a 16-entry FIFO with the consumer stalled.
    bus.rx_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      if (i <= DEPTH) rx_exp.push_back({8'(i), 8'h90, 8'(4 + i)});
      send_rx(8'(i), 1'b1);
    end
    wait_clk(BIT);
    @(negedge CLOCK_25);
    check("t5_overflow", 32'(bus.rx_overflow), 32'(1));
    check("t5_rx_valid", 32'(bus.rx_valid), 32'(1));
    check("t5_framing_err", 32'(bus.rx_framing_err), 32'(0));
    bus.rx_ready = 1'b1;
    for (int n = 0; n < 200 && rx_exp.size() != 0; n++) wait_clk(1);
    wait_clk(2);
    check("t5_drained", 32'(rx_exp.size()), 32'(0));
    check("t5_rx_valid_end", 32'(bus.rx_valid), 32'(0));
    bus.err_clr = 1'b1;
    wait_clk(1);
    bus.err_clr = 1'b0;
    @(negedge CLOCK_25);
    check("t5_overflow_clr", 32'(bus.rx_overflow), 32'(0));

    // Back-to-back TX pushes.
    tx_exp.push_back(8'h90);
    tx_exp.push_back(8'h3C);
`ifndef MIDI_TX_RUNNING_STATUS_EN
    tx_exp.push_back(8'h90);
`endif
    tx_exp.push_back(8'h40);
    tx_starts.delete();
    foreach (tx_exp[i]) begin end
    begin
      logic [7:0] pushes [4];
      pushes[0] = 8'h90; pushes[1] = 8'h3C; pushes[2] = 8'h90; pushes[3] = 8'h40;
      for (int i = 0; i < 4; i++) begin
        @(negedge CLOCK_25);
        check("t6_tx_ready", 32'(bus.tx_ready), 32'(1));
        wait_clk(0);
        bus.tx_data  = pushes[i];
        bus.tx_valid = 1'b1;
        wait_clk(1);
      end
      bus.tx_valid = 1'b0;
    end
    @(negedge CLOCK_25);
    check("t6_tx_busy", 32'(bus.tx_busy), 32'(1));
    for (int n = 0; n < 50 * BIT && bus.tx_busy; n++) wait_clk(1);
    wait_clk(BIT);
    @(negedge CLOCK_25);
    check("t6_tx_idle", 32'({bus.tx_busy, bus.tx_ready, midi_txd}), 32'(3'b011));
    check("t6_tx_pending", 32'(tx_exp.size()), 32'(0));
    check("t6_frame_count", 32'(tx_starts.size()), 32'(N_TX));
    for (int i = 1; i < tx_starts.size(); i++)
      check("t6_frame_spacing", 32'(tx_starts[i] - tx_starts[i-1]), 32'(10 * BIT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
